// File: rtl/alu_sout_receiver.sv
// Receiver behind the serial ALU output: deserializes 11-bit packets and decodes OK/error responses.
// Latency: result strobe one cycle after the CTL stop bit; no backpressure (line cannot be stalled).
module alu_sout_receiver #(
  parameter int          DATA_BYTES = 4,
  parameter logic [2:0]  CRC_POLY   = 3'b011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic        res_crc_ok,
  output logic        res_err,
  output logic [5:0]  res_err_flags,
  output logic        res_parity_ok,
  output logic        proto_err
);

  localparam int             CW   = $clog2(DATA_BYTES + 1);
  localparam logic [CW-1:0]  FULL = CW'(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, TYPE, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic           typ;
  logic [7:0]     sh;
  logic [2:0]     bcnt;
  logic [CW-1:0]  cnt;
  logic [31:0]    acc;

  logic           deliver;
  logic           frame_err;
  logic           data_acc;
  logic           ok_rsp;
  logic           err_rsp;
  logic           seq_err;
  logic [2:0]     crc_calc;

  // MSB-first serial CRC3 over {C, 1'b0, flags}, seeded with zero.
  function automatic logic [2:0] crc3(input logic [36:0] bits);
    logic [2:0] s;
    logic       fb;
    s = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = s[2] ^ bits[i];
      s  = {s[1:0], 1'b0} ^ (fb ? CRC_POLY : 3'b000);
    end
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: if (!sin) state_nxt = TYPE;
      TYPE: state_nxt = DATA;
      DATA: if (bcnt == 3'd0) state_nxt = STOP;
      STOP: begin
        state_nxt = IDLE;
        deliver   = sin;
        frame_err = !sin;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      typ  <= 1'b0;
      sh   <= 8'h00;
      bcnt <= 3'd0;
    end else begin
      case (state)
        TYPE: begin
          typ  <= sin;
          bcnt <= 3'd7;
        end
        DATA: begin
          sh   <= {sh[6:0], sin};
          bcnt <= bcnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Byte-level sequencing; the shift register holds the complete byte while in STOP.
  always_comb begin
    data_acc = deliver && !typ && (cnt < FULL);
    ok_rsp   = deliver && typ && !sh[7] && (cnt == FULL);
    err_rsp  = deliver && typ && sh[7] && (cnt == '0);
    seq_err  = deliver && !(data_acc || ok_rsp || err_rsp);
    crc_calc = crc3({acc, 1'b0, sh[6:3]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      acc           <= 32'h0;
      res_valid     <= 1'b0;
      proto_err     <= 1'b0;
      res_data      <= 32'h0;
      res_flags     <= 4'h0;
      res_crc_ok    <= 1'b0;
      res_err       <= 1'b0;
      res_err_flags <= 6'h0;
      res_parity_ok <= 1'b0;
    end else begin
      res_valid <= ok_rsp || err_rsp;
      proto_err <= frame_err || seq_err;
      if (data_acc) begin
        acc <= {acc[23:0], sh};
        cnt <= cnt + CW'(1);
      end
      if (frame_err || seq_err) cnt <= '0;
      if (ok_rsp) begin
        cnt           <= '0;
        res_data      <= acc;
        res_flags     <= sh[6:3];
        res_crc_ok    <= (crc_calc == sh[2:0]);
        res_err       <= 1'b0;
        res_err_flags <= 6'h0;
        res_parity_ok <= 1'b0;
      end
      if (err_rsp) begin
        cnt           <= '0;
        res_data      <= 32'h0;
        res_flags     <= 4'h0;
        res_crc_ok    <= 1'b0;
        res_err       <= 1'b1;
        res_err_flags <= sh[6:1];
        res_parity_ok <= ~^sh;
      end
    end
  end

endmodule

// File: tb/tb_alu_sout_receiver.sv
// Bench for alu_sout_receiver: serial packet driver, expected-response queue, negedge monitor.
module tb_alu_sout_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        res_crc_ok;
  logic        res_err;
  logic [5:0]  res_err_flags;
  logic        res_parity_ok;
  logic        proto_err;

  alu_sout_receiver #(.DATA_BYTES(4), .CRC_POLY(3'b011)) dut (
    .clk(clk), .rst(rst), .sin(sin),
    .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
    .res_crc_ok(res_crc_ok), .res_err(res_err), .res_err_flags(res_err_flags),
    .res_parity_ok(res_parity_ok), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        crc_ok;
    logic [5:0]  eflags;
    logic        par_ok;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   perr_cnt = 0;
  int   n_valid  = 0;

  always @(posedge clk) cyc++;

  // Monitor: every strobe is popped against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (proto_err) perr_cnt++;
    if (res_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_res_valid cycle=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== e.cyc) begin n_fail++; $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc, e.cyc); end
        n_cmp++;
        if (res_err !== e.is_err) begin n_fail++; $display("FAIL res_err got=%b want=%b", res_err, e.is_err); end
        n_cmp++;
        if (res_err_flags !== e.eflags) begin n_fail++; $display("FAIL res_err_flags got=%b want=%b", res_err_flags, e.eflags); end
        if (e.is_err) begin
          n_cmp++;
          if (res_parity_ok !== e.par_ok) begin n_fail++; $display("FAIL res_parity_ok got=%b want=%b", res_parity_ok, e.par_ok); end
        end else begin
          n_cmp++;
          if (res_data !== e.data) begin n_fail++; $display("FAIL res_data got=%h want=%h", res_data, e.data); end
          n_cmp++;
          if (res_flags !== e.flags) begin n_fail++; $display("FAIL res_flags got=%b want=%b", res_flags, e.flags); end
          n_cmp++;
          if (res_crc_ok !== e.crc_ok) begin n_fail++; $display("FAIL res_crc_ok got=%b want=%b", res_crc_ok, e.crc_ok); end
        end
      end
    end
  end

  function automatic logic [2:0] model_crc(input logic [36:0] bits);
    logic [2:0] s;
    logic       fb;
    s = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = s[2] ^ bits[i];
      s  = {s[1], s[0] ^ fb, fb};
    end
    return s;
  endfunction

  task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, typ, d, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = bits[i];
      @(posedge clk); #1;
    end
    sin = 1'b1;
  endtask

  task automatic send_rsp(input logic [31:0] c, input logic [7:0] ctl, input logic crc_ok);
    exp_t e;
    for (int b = 3; b >= 0; b--) send_pkt(1'b0, c[8*b +: 8], 1'b1);
    e.is_err = 1'b0; e.data = c; e.flags = ctl[6:3]; e.crc_ok = crc_ok;
    e.eflags = 6'h0; e.par_ok = 1'b0; e.cyc = cyc + 11;
    exp_q.push_back(e);
    send_pkt(1'b1, ctl, 1'b1);
  endtask

  task automatic send_err(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b1; e.data = 32'h0; e.flags = 4'h0; e.crc_ok = 1'b0;
    e.eflags = d[6:1]; e.par_ok = ~^d; e.cyc = cyc + 11;
    exp_q.push_back(e);
    send_pkt(1'b1, d, 1'b1);
  endtask

  task automatic settle(input string name);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_strobes outstanding=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({res_valid, res_data, res_flags, res_crc_ok, res_err, res_err_flags, res_parity_ok, proto_err} !== 47'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", {res_valid, res_data, res_flags, res_crc_ok, res_err, res_err_flags, res_parity_ok, proto_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ok_basic();
    send_rsp(32'h0, 8'h16, 1'b1);
    settle("ok_basic");
    send_rsp(32'h0, 8'h17, 1'b0);
    settle("ok_badcrc");
  endtask

  task automatic test_err_rsp();
    send_err(8'h93);
    settle("err_93");
    send_err(8'h92);
    settle("err_92");
  endtask

  task automatic test_framing();
    int p0, v0;
    logic [31:0] c;
    p0 = perr_cnt; v0 = n_valid;
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL framing_proto_err got=%0d want=1", perr_cnt - p0); end
    n_cmp++;
    if (n_valid !== v0) begin n_fail++; $display("FAIL framing_no_valid got=%0d want=0", n_valid - v0); end
    c = 32'h12345678;
    send_rsp(c, {1'b0, 4'b1001, model_crc({c, 1'b0, 4'b1001})}, 1'b1);
    settle("framing_recover");
  endtask

  task automatic test_seq_errs();
    int p0, v0;
    p0 = perr_cnt; v0 = n_valid;
    send_pkt(1'b0, 8'hAA, 1'b1);
    send_pkt(1'b0, 8'h55, 1'b1);
    send_pkt(1'b1, 8'h16, 1'b1);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL short_ctl_proto_err got=%0d want=1", perr_cnt - p0); end
    n_cmp++;
    if (n_valid !== v0) begin n_fail++; $display("FAIL short_ctl_no_valid got=%0d want=0", n_valid - v0); end
    p0 = perr_cnt;
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'(i + 1), 1'b1);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (perr_cnt - p0 !== 0) begin n_fail++; $display("FAIL four_data_proto_err got=%0d want=0", perr_cnt - p0); end
    send_pkt(1'b0, 8'h05, 1'b1);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL fifth_data_proto_err got=%0d want=1", perr_cnt - p0); end
    n_cmp++;
    if (n_valid !== v0) begin n_fail++; $display("FAIL fifth_data_no_valid got=%0d want=0", n_valid - v0); end
  endtask

  task automatic test_random();
    logic [31:0] c;
    logic [3:0]  f;
    logic        bad;
    logic [7:0]  d;
    for (int i = 0; i < 6; i++) begin
      c   = $urandom;
      f   = 4'($urandom_range(0, 15));
      bad = 1'($urandom_range(0, 1));
      send_rsp(c, {1'b0, f, model_crc({c, 1'b0, f}) ^ {2'b00, bad}}, !bad);
      d = {1'b1, 7'($urandom_range(0, 127))};
      send_err(d);
    end
    settle("random");
  endtask

  task automatic test_reset_mid();
    logic [31:0] c;
    c = 32'hCAFEF00D;
    send_rsp(c, {1'b0, 4'b1111, model_crc({c, 1'b0, 4'b1111})}, 1'b1);
    settle("pre_reset");
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    sin = 1'b0; @(posedge clk); #1;
    sin = 1'b0; @(posedge clk); #1;
    sin = 1'b1; @(posedge clk); #1;
    rst = 1'b1; sin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_data !== 32'h0) begin n_fail++; $display("FAIL midreset_res_data got=%h want=0", res_data); end
    n_cmp++;
    if ({res_valid, res_flags, res_crc_ok, proto_err} !== 7'h0) begin
      n_fail++; $display("FAIL midreset_ctrl got=%h want=0", {res_valid, res_flags, res_crc_ok, proto_err});
    end
    @(posedge clk); #1;
    c = 32'hDEADBEEF;
    send_rsp(c, {1'b0, 4'b0101, model_crc({c, 1'b0, 4'b0101})}, 1'b1);
    settle("deadbeef");
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [31:0] c;
    v0 = n_valid;
    c = 32'h80000001;
    send_rsp(c, {1'b0, 4'b1000, model_crc({c, 1'b0, 4'b1000})}, 1'b1);
    c = 32'h00FF00FF;
    send_rsp(c, {1'b0, 4'b0001, model_crc({c, 1'b0, 4'b0001})}, 1'b1);
    send_err(8'hFE);
    settle("back_to_back");
    n_cmp++;
    if (n_valid - v0 !== 3) begin n_fail++; $display("FAIL back_to_back_strobes got=%0d want=3", n_valid - v0); end
  endtask

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    test_reset();
    test_ok_basic();
    test_err_rsp();
    test_framing();
    test_seq_errs();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
